// File: rtl/myproject_div_pkg.sv
// Shared types and constants for the sequential signed-by-unsigned divider.
package myproject_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam int unsigned DIN0_W = 44;
    localparam int unsigned DIN1_W = 25;
    localparam int unsigned DOUT_W = 19;
    localparam int unsigned CNT_W  = 6;

    localparam int QMAX = 262143;
    localparam int QMIN = -262144;

endpackage

// File: rtl/myproject_div_restore_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore.
module myproject_div_restore_step
    import myproject_div_pkg::*;
(
    input  logic [DIN1_W-1:0] pr,
    input  logic              nbit,
    input  logic [DIN1_W-1:0] divisor,
    output logic [DIN1_W-1:0] pr_next,
    output logic              qbit
);

    logic [DIN1_W:0] shifted;
    logic [DIN1_W:0] sub;

    // Partial remainder stays below the divisor, so the result fits DIN1_W bits.
    always_comb begin
        shifted = {pr, nbit};
        sub     = shifted - {1'b0, divisor};
        qbit    = (shifted >= {1'b0, divisor});
        pr_next = DIN1_W'(qbit ? sub : shifted);
    end

endmodule

// File: rtl/myproject_sdiv_44s_25ns_seq.sv
// Sequential 44-bit signed / 25-bit unsigned restoring divider.
// Start/done handshake, 45-cycle latency. Build option MYPROJECT_DIV_SAT_EN
// saturates the quotient on overflow instead of wrapping it.
module myproject_sdiv_44s_25ns_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 44,
    parameter int din1_WIDTH = 25,
    parameter int dout_WIDTH = 19
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div0,
    output logic                  ovf
);

    import myproject_div_pkg::*;

    state_t state, state_nx;

    logic [DIN0_W-1:0] dvd;     // dividend magnitude, consumed MSB first
    logic [DIN0_W-1:0] quo;     // quotient magnitude
    logic [DIN1_W-1:0] dsr;
    logic [DIN1_W-1:0] prem;
    logic [DIN1_W-1:0] dlo;     // original dividend low bits for the div0 remainder
    logic              neg;
    logic [CNT_W-1:0]  cnt;

    logic [DIN1_W-1:0] prem_nx;
    logic              qbit;

    logic [DIN0_W-1:0] qs;
    logic              ov_mag;
    logic [DOUT_W-1:0] sat_q;
    logic [DOUT_W-1:0] res_q;
    logic [DIN1_W-1:0] res_r;
    logic              res_d0;
    logic              res_ov;

    myproject_div_restore_step u_step (
        .pr      (prem),
        .nbit    (dvd[DIN0_W-1]),
        .divisor (dsr),
        .pr_next (prem_nx),
        .qbit    (qbit)
    );

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == CNT_W'(DIN0_W - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sign fix-up, range check and divide-by-zero selection of the final result.
    always_comb begin
        qs     = neg ? (~quo + 1'b1) : quo;
        ov_mag = neg ? (quo > DIN0_W'(-QMIN)) : (quo > DIN0_W'(QMAX));
        sat_q  = neg ? DOUT_W'(QMIN) : DOUT_W'(QMAX);
        res_q  = qs[DOUT_W-1:0];
        res_r  = neg ? (~prem + 1'b1) : prem;
        res_d0 = 1'b0;
        res_ov = 1'b0;
        if (dsr == '0) begin
            res_d0 = 1'b1;
            res_q  = sat_q;
            res_r  = dlo;
        end else begin
            res_ov = ov_mag;
`ifdef MYPROJECT_DIV_SAT_EN
            if (ov_mag) res_q = sat_q;
`endif
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dvd  <= '0;
            quo  <= '0;
            dsr  <= '0;
            prem <= '0;
            dlo  <= '0;
            neg  <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
            dout <= '0;
            rem  <= '0;
            div0 <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd  <= din0[DIN0_W-1] ? (~din0 + 1'b1) : din0;
                        neg  <= din0[DIN0_W-1];
                        dsr  <= din1;
                        dlo  <= din0[DIN1_W-1:0];
                        prem <= '0;
                        quo  <= '0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    prem <= prem_nx;
                    quo  <= {quo[DIN0_W-2:0], qbit};
                    dvd  <= {dvd[DIN0_W-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    dout <= res_q;
                    rem  <= res_r;
                    div0 <= res_d0;
                    ovf  <= res_ov;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_myproject_sdiv_44s_25ns_seq.sv
// Self-checking bench for the sequential divider: directed table, random
// vectors against an arithmetic model, and handshake/reset sequences.
module tb_myproject_sdiv_44s_25ns_seq;

`ifdef MYPROJECT_DIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        start  = 1'b0;
    logic [43:0] din0   = '0;
    logic [24:0] din1   = '0;
    logic        busy;
    logic        done;
    logic [18:0] dout;
    logic [24:0] rem;
    logic        div0;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    myproject_sdiv_44s_25ns_seq #(
        .ID(1), .din0_WIDTH(44), .din1_WIDTH(25), .dout_WIDTH(19)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .din0(din0), .din1(din1),
        .busy(busy), .done(done), .dout(dout), .rem(rem), .div0(div0), .ovf(ovf)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint r;
        bit     d0;
        bit     ov;
    } vec_t;

    function automatic longint sx19(input logic [18:0] v);
        logic signed [18:0] t;
        t = v;
        return longint'(t);
    endfunction

    function automatic longint sx25(input logic [24:0] v);
        logic signed [24:0] t;
        t = v;
        return longint'(t);
    endfunction

    function automatic longint sx44(input logic [43:0] v);
        logic signed [43:0] t;
        t = v;
        return longint'(t);
    endfunction

    // Plain-arithmetic reference: truncating division, remainder follows dividend.
    task automatic model(input longint a, input longint b,
                         output longint q, output longint r, output bit d0, output bit ov);
        longint qq, rr;
        if (b == 0) begin
            d0 = 1'b1;
            ov = 1'b0;
            q  = (a >= 0) ? 262143 : -262144;
            rr = a;
            r  = sx25(rr[24:0]);
        end else begin
            d0 = 1'b0;
            qq = a / b;
            rr = a % b;
            ov = (qq > 262143) || (qq < -262144);
            if (ov && SAT) q = (qq > 0) ? 262143 : -262144;
            else           q = sx19(qq[18:0]);
            r = sx25(rr[24:0]);
        end
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic launch(input longint a, input longint b);
        @(negedge ap_clk);
        start = 1'b1;
        din0  = a[43:0];
        din1  = b[24:0];
        @(posedge ap_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge ap_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input longint a, input longint b);
        longint q, r;
        bit d0, ov;
        model(a, b, q, r, d0, ov);
        chk({tag, ".dout"}, sx19(dout), q);
        chk({tag, ".rem"}, sx25(rem), r);
        chk({tag, ".div0"}, longint'(div0), longint'(d0));
        chk({tag, ".ovf"}, longint'(ovf), longint'(ov));
    endtask

    vec_t tbl[13];

    initial begin
        int cyc;
        int ndone;
        int first;
        longint a, b;

        tbl[0]  = '{1000, 10, 100, 0, 1'b0, 1'b0};
        tbl[1]  = '{-1000, 7, -142, -6, 1'b0, 1'b0};
        tbl[2]  = '{5, 0, 262143, 5, 1'b1, 1'b0};
        tbl[3]  = '{-5, 0, -262144, -5, 1'b1, 1'b0};
        tbl[4]  = '{64'sd1 <<< 30, 1, SAT ? 262143 : 0, 0, 1'b0, 1'b1};
        tbl[5]  = '{-(64'sd1 <<< 43), 1, SAT ? -262144 : 0, 0, 1'b0, 1'b1};
        tbl[6]  = '{262143, 1, 262143, 0, 1'b0, 1'b0};
        tbl[7]  = '{-262144, 1, -262144, 0, 1'b0, 1'b0};
        tbl[8]  = '{262144, 1, SAT ? 262143 : -262144, 0, 1'b0, 1'b1};
        tbl[9]  = '{(64'sd1 <<< 43) - 1, (64'sd1 <<< 25) - 1, SAT ? 262143 : -262144, 262143, 1'b0, 1'b1};
        tbl[10] = '{-7, 2, -3, -1, 1'b0, 1'b0};
        tbl[11] = '{-(64'sd1 <<< 43), 0, -262144, 0, 1'b1, 1'b0};
        tbl[12] = '{1000, (64'sd1 <<< 25) - 1, 0, 1000, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst.busy", longint'(busy), 0);
        chk("rst.done", longint'(done), 0);
        chk("rst.dout", longint'(dout), 0);
        chk("rst.rem", longint'(rem), 0);
        chk("rst.div0", longint'(div0), 0);
        chk("rst.ovf", longint'(ovf), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            launch(tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d.busy", i), longint'(busy), 1);
            wait_done(cyc);
            chk($sformatf("tbl%0d.lat", i), cyc, 45);
            chk($sformatf("tbl%0d.busy_done", i), longint'(busy), 0);
            chk($sformatf("tbl%0d.dout", i), sx19(dout), tbl[i].q);
            chk($sformatf("tbl%0d.rem", i), sx25(rem), tbl[i].r);
            chk($sformatf("tbl%0d.div0", i), longint'(div0), longint'(tbl[i].d0));
            chk($sformatf("tbl%0d.ovf", i), longint'(ovf), longint'(tbl[i].ov));
        end

        // Random vectors against the model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0:       a = sx44({$urandom, $urandom});
                1:       a = longint'($urandom_range(0, 2097152)) - 1048576;
                default: a = longint'($urandom_range(0, 20000000)) - 10000000;
            endcase
            case ($urandom_range(0, 9))
                0:       b = 0;
                1, 2, 3: b = longint'($urandom_range(1, 1000));
                default: b = longint'($urandom_range(1, 33554431));
            endcase
            launch(a, b);
            wait_done(cyc);
            chk($sformatf("rnd%0d.lat", i), cyc, 45);
            check_result($sformatf("rnd%0d", i), a, b);
        end

        // Start while busy is ignored
        launch(1000, 10);
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 10) begin
                start = 1'b1;
                din0  = 44'd7;
                din1  = 25'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge ap_clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first = c;
                    check_result("ign", 1000, 10);
                end
            end
        end
        start = 1'b0;
        chk("ign.ndone", ndone, 1);
        chk("ign.lat", first, 45);

        // Start in the done cycle is accepted
        launch(-1000, 7);
        wait_done(cyc);
        chk("b2b.lat1", cyc, 45);
        launch(123456789, 1000);
        chk("b2b.busy", longint'(busy), 1);
        wait_done(cyc);
        chk("b2b.lat2", cyc, 45);
        check_result("b2b", 123456789, 1000);

        // Reset mid-operation aborts with no done
        launch(5, 0);
        repeat (20) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("abort.busy", longint'(busy), 0);
        chk("abort.done", longint'(done), 0);
        chk("abort.dout", longint'(dout), 0);
        chk("abort.rem", longint'(rem), 0);
        chk("abort.div0", longint'(div0), 0);
        chk("abort.ovf", longint'(ovf), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(posedge ap_clk);
            #1;
            if (done) ndone++;
        end
        chk("abort.ndone", ndone, 0);

        // Reset has priority over start
        @(negedge ap_clk);
        ap_rst = 1'b1;
        start  = 1'b1;
        din0   = 44'd100;
        din1   = 25'd3;
        @(posedge ap_clk);
        #1;
        chk("rstprio.busy", longint'(busy), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        start  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/myproject_sdiv_44s_25ns_seq.md
# myproject_sdiv_44s_25ns_seq

Sequential signed-by-unsigned divider that undoes the layer-norm scaling product: a 44-bit signed dividend is divided by a 25-bit unsigned divisor, yielding a 19-bit signed quotient and a 25-bit signed remainder. It is a restoring radix-2 engine that retires one quotient bit per clock, and it sits beside the combinational 25ns×19s→44 multiplier in the normalization datapath. Start/done pulse handshake.

## Interface
- ID, 1, instance tag; no functional effect
- din0_WIDTH, 44, dividend width, signed
- din1_WIDTH, 25, divisor width, unsigned
- dout_WIDTH, 19, quotient width, signed
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  reset; synchronous and active-high
- start  in  1  request; sampled only when busy=0
- din0  in  din0_WIDTH  dividend; sampled with accepted start
- din1  in  din1_WIDTH  divisor; sampled with accepted start
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; results valid
- dout  out  dout_WIDTH  quotient, held until next done
- rem  out  din1_WIDTH  remainder, signed, held until next done
- div0  out  1  divisor was zero, held with dout
- ovf  out  1  quotient exceeded dout range, held with dout

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 → latch |din0| as 44-bit unsigned, din1, dividend sign; clear the partial remainder; count=0; go to CALC.
- CALC: each cycle, shift the partial remainder left and bring in the next dividend MSB. Trial-subtract din1; if the result is non-negative keep it and set the quotient bit to 1, else restore. count++. After 44 iterations (count=43), go to FIX.
- FIX: apply the sign. The quotient truncates toward zero, and the remainder takes the dividend's sign. Register dout/rem/div0/ovf, pulse done, go to IDLE.
- Range: the quotient is in range if it lies within [-2^18, 2^18-1]; otherwise ovf=1, and the dout value is set by the Configuration macro.
- Divide-by-zero: div0=1 and ovf=0. dout=2^18-1 if the dividend ≥0, else -2^18. rem = the low 25 bits of din0.
- Dividend -2^43 is handled: its magnitude 2^43 fits in 44 unsigned bits.
- start while busy=1 is ignored; inputs are not re-sampled.

## Timing
- Reset: state=IDLE; busy, done, div0, ovf = 0; dout, rem = 0.
- start accepted at edge N → busy=1 from N through N+45. CALC edges are N+1..N+44, and the FIX edge is N+45. done=1 during the cycle after edge N+45. Latency: 45 cycles.
- busy=0 in the done cycle, so a start in the done cycle is accepted. Back-to-back throughput is one result per 45 cycles.
- ap_rst mid-operation: abort to IDLE, no done, outputs return to reset values.
- ap_rst has priority over start in the same cycle.

## Configuration
- MYPROJECT_DIV_SAT_EN defined: on ovf, dout saturates to 2^18-1 (positive) or -2^18 (negative).
- Undefined: dout = the low 19 bits of the signed quotient (wrap). ovf is still reported.
- The div0 result is identical in both builds.

## Structure
- Package myproject_div_pkg:
  - state enum: IDLE, CALC, FIX
  - width constants 44, 25, 19
  - QMAX = 2^18-1, QMIN = -2^18
  - iteration-count width: 6 bits
- Sub-module myproject_div_restore_step: combinational single iteration. Inputs: partial remainder, next bit, divisor. Outputs: new partial remainder, quotient bit.

## Test plan
- 1000 ÷ 10 → dout=100, rem=0, div0=0, ovf=0; done 45 cycles after start.
- -1000 ÷ 7 → dout=-142, rem=-6.
- 5 ÷ 0 → div0=1, dout=262143; -5 ÷ 0 → dout=-262144.
- 2^30 ÷ 1 → ovf=1; dout=262143 with SAT_EN, dout=0 without. -2^43 ÷ 1 → ovf=1, dout=-262144 with SAT_EN.
- Second start at cycle 10 of an operation → ignored; one done; the result matches the first operands. A start in the done cycle → accepted; the next done comes 45 cycles later.
- ap_rst asserted at cycle 20 of CALC → busy=0 and all outputs 0 on the next cycle; no done ever appears for that operation.
